// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
// Shift-add multiply and restoring divide share one 2*WIDTH working register.
// Operands are reduced to magnitudes first, and the signs are restored at the end.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcl,
    input  logic [WIDTH-1:0] RTdata,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_srcA;
    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic               r_resSign;
    logic               r_remSign;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // op[1] selects divide, op[0] selects signed operands
    logic               w_isDiv;
    logic               w_isSigned;
    logic [WIDTH-1:0]   w_aMag;
    logic [WIDTH-1:0]   w_bMag;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_divNext;
    logic [2*WIDTH-1:0] w_prodNeg;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_resHi;
    logic [WIDTH-1:0]   w_resLo;
    logic               w_lastIter;

    assign w_isDiv    = r_op[1];
    assign w_isSigned = r_op[0];
    assign w_lastIter = (r_cnt == CW'(WIDTH - 1));

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

    // Operand magnitudes, one iteration of each algorithm, and the final sign-corrected result
    always_comb begin
        w_aMag     = (w_isSigned && r_opA[WIDTH-1]) ? (~r_opA + WIDTH'(1)) : r_opA;
        w_bMag     = (w_isSigned && r_opB[WIDTH-1]) ? (~r_opB + WIDTH'(1)) : r_opB;

        w_addend   = r_prod[0] ? {1'b0, r_opA} : '0;
        w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + w_addend;
        w_mulNext  = {w_sum, r_prod[WIDTH-1:1]};

        w_remShift = r_prod[2*WIDTH-1:WIDTH-1];
        w_trial    = w_remShift - {1'b0, r_opB};
        if (w_trial[WIDTH]) begin
            w_divNext = {w_remShift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
        end else begin
            w_divNext = {w_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
        end

        w_prodNeg  = ~r_prod + (2*WIDTH)'(1);
        w_quo      = r_prod[WIDTH-1:0];
        w_rem      = r_prod[2*WIDTH-1:WIDTH];

        w_resHi    = r_prod[2*WIDTH-1:WIDTH];
        w_resLo    = r_prod[WIDTH-1:0];
        if (w_isDiv) begin
            if (r_opB == '0) begin
                w_resHi = r_srcA;
                w_resLo = '1;
            end else begin
                w_resLo = (w_isSigned && r_resSign) ? (~w_quo + WIDTH'(1)) : w_quo;
                w_resHi = (w_isSigned && r_remSign) ? (~w_rem + WIDTH'(1)) : w_rem;
            end
        end else if (w_isSigned && r_resSign) begin
            w_resHi = w_prodNeg[2*WIDTH-1:WIDTH];
            w_resLo = w_prodNeg[WIDTH-1:0];
        end
    end

    // Next-state logic: PREP and FIX take one cycle each, CALC runs WIDTH iterations
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (start) w_stateNext = PREP;
            PREP:    w_stateNext = CALC;
            CALC:    if (w_lastIter) w_stateNext = FIX;
            FIX:     w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath: operand latch, iteration work, and HI/LO updates from FIX or MTHI/MTLO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_srcA    <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_resSign <= 1'b0;
            r_remSign <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_op   <= op;
                        r_srcA <= srcl;
                        r_opA  <= srcl;
                        r_opB  <= RTdata;
                    end
                end
                PREP: begin
                    r_opA     <= w_aMag;
                    r_opB     <= w_bMag;
                    r_resSign <= w_isSigned & (r_opA[WIDTH-1] ^ r_opB[WIDTH-1]);
                    r_remSign <= w_isSigned & r_opA[WIDTH-1];
                    r_cnt     <= '0;
                    r_prod    <= w_isDiv ? {{WIDTH{1'b0}}, w_aMag} : {{WIDTH{1'b0}}, w_bMag};
                end
                CALC: begin
                    r_prod <= w_isDiv ? w_divNext : w_mulNext;
                    r_cnt  <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_hi   <= w_resHi;
                    r_lo   <= w_resLo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
